// File: rtl/tl_ul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_pkg : TileLink-UL opcodes, D response record, lane-mask helper  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tl_ul_pkg;

  localparam int TL_SRC_MAX_W = 8;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4,
    A_HINT        = 3'd5
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_opcode_e;

  typedef struct packed {
    d_opcode_e               opcode;
    logic [3:0]              size;
    logic [TL_SRC_MAX_W-1:0] source;
    logic                    denied;
    logic                    corrupt;
    logic [31:0]             data;
  } d_resp_t;

  function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] addr_lo);
    case (size)
      4'd0:    lane_mask = 4'b0001 << addr_lo;
      4'd1:    lane_mask = 4'b0011 << {addr_lo[1], 1'b0};
      default: lane_mask = 4'hF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_ul_req_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_req_check : combinational A-request legality and lane mask      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tl_ul_req_check
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic [2:0]  i_opcode,
  input  logic [3:0]  i_size,
  input  logic [31:0] i_address,
  input  logic [3:0]  i_mask,
  output logic        o_denied,
  output logic [3:0]  o_lane_mask,
  output logic [31:0] o_offset
);

  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  logic w_size_bad;
  logic w_misaligned;
  logic w_range_bad;
  logic w_op_bad;
  logic w_mask_bad;

  always_comb begin
    // Wraps modulo 2^32, so addresses below the base land far out of range.
    o_offset     = i_address - BASE_ADDR;
    o_lane_mask  = lane_mask(i_size, i_address[1:0]);
    w_size_bad   = i_size > 4'd2;
    w_misaligned = ((i_size == 4'd1) && i_address[0]) ||
                   ((i_size == 4'd2) && (i_address[1:0] != 2'b00));
    w_range_bad  = {1'b0, o_offset} >= SPAN;
    w_op_bad     = 1'b0;
    w_mask_bad   = 1'b0;
    case (a_opcode_e'(i_opcode))
      A_PUT_FULL, A_GET: w_mask_bad = (i_mask != o_lane_mask);
      A_PUT_PARTIAL:     w_mask_bad = ((i_mask & ~o_lane_mask) != 4'h0);
      A_HINT:            w_mask_bad = 1'b0;
      default:           w_op_bad   = 1'b1;
    endcase
    o_denied = w_size_bad | w_misaligned | w_range_bad | w_op_bad | w_mask_bad;
  end

endmodule
`default_nettype wire

// File: rtl/tl_ul_d_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_ul_d_responder : TL-UL slave with flop scratchpad, 1-cycle D resp  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tl_ul_d_responder
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          SOURCE_W    = 3,
  parameter logic        SINK_ID     = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [3:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [3:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt,
  output logic [7:0]          err_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [3:0][7:0] r_mem [DEPTH_WORDS];
  d_resp_t         r_resp;
  logic            r_valid;
  logic [7:0]      r_err;

  d_resp_t         w_resp;
  logic            w_fire;
  logic            w_d_fire;
  logic            w_denied;
  logic            w_write;
  logic [3:0]      w_lane;
  logic [31:0]     w_offset;
  logic [IDX_W-1:0] w_idx;
  logic            w_unused;

  tl_ul_req_check #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_check (
    .i_opcode    (a_opcode),
    .i_size      (a_size),
    .i_address   (a_address),
    .i_mask      (a_mask),
    .o_denied    (w_denied),
    .o_lane_mask (w_lane),
    .o_offset    (w_offset)
  );

  assign w_idx    = w_offset[IDX_W+1:2];
  assign a_ready  = reset_n & (~r_valid | d_ready);
  assign w_fire   = a_valid & a_ready;
  assign w_d_fire = r_valid & d_ready;
  assign w_write  = w_fire & ~w_denied & ~a_corrupt &
                    ((a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL));
  assign w_unused = ^{a_param, w_lane, w_offset[31:IDX_W+2], w_offset[1:0], r_resp.source};

  always_comb begin
    w_resp        = '0;
    w_resp.size   = a_size;
    w_resp.source = TL_SRC_MAX_W'(a_source);
    w_resp.denied = w_denied;
    case (a_opcode_e'(a_opcode))
      A_PUT_FULL, A_PUT_PARTIAL: w_resp.opcode = D_ACCESS_ACK;
      A_HINT:                    w_resp.opcode = D_HINT_ACK;
      A_GET: begin
        w_resp.opcode  = D_ACCESS_ACK_DATA;
        w_resp.corrupt = w_denied;
        w_resp.data    = w_denied ? 32'h0 : r_mem[w_idx];
      end
      default: begin
        // Opcodes 2/3 expect data back, 6/7 do not; all are refused.
        w_resp.opcode  = a_opcode[2] ? D_ACCESS_ACK : D_ACCESS_ACK_DATA;
        w_resp.corrupt = ~a_opcode[2];
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (a_mask[i]) r_mem[w_idx][i] <= a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_resp  <= '0;
      r_err   <= 8'h00;
    end else begin
      if (w_fire) begin
        r_valid <= 1'b1;
        r_resp  <= w_resp;
      end else if (w_d_fire) begin
        r_valid <= 1'b0;
      end
      if (w_d_fire && r_resp.denied && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  assign d_valid   = r_valid;
  assign d_opcode  = r_resp.opcode;
  assign d_param   = 2'b00;
  assign d_size    = r_resp.size;
  assign d_source  = r_resp.source[SOURCE_W-1:0];
  assign d_sink    = SINK_ID;
  assign d_denied  = r_resp.denied;
  assign d_data    = r_resp.data;
  assign d_corrupt = r_resp.corrupt;
  assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_d_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tl_ul_d_responder : randomized bench with behavioural TL-UL model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tl_ul_d_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;
  localparam int          SW    = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_valid = 1'b0;
  logic [2:0]    a_opcode = 3'd0;
  logic [2:0]    a_param = 3'd0;
  logic [3:0]    a_size = 4'd0;
  logic [SW-1:0] a_source = '0;
  logic [31:0]   a_address = 32'h0;
  logic [3:0]    a_mask = 4'h0;
  logic [31:0]   a_data = 32'h0;
  logic          a_corrupt = 1'b0;
  logic          d_ready = 1'b1;
  logic          a_ready, d_valid, d_sink, d_denied, d_corrupt;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [3:0]    d_size;
  logic [SW-1:0] d_source;
  logic [31:0]   d_data;
  logic [7:0]    err_count;

  tl_ul_d_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .SOURCE_W(SW), .SINK_ID(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: scratchpad as bytes, one pending response slot.
  logic [7:0]    mbytes [4*DEPTH];
  logic          m_valid;
  logic [2:0]    m_op;
  logic [3:0]    m_size;
  logic [SW-1:0] m_src;
  logic          m_den, m_cor;
  logic [31:0]   m_data;
  int            m_err;

  always @(posedge clock) begin : model
    logic [31:0] off;
    logic [3:0]  lm;
    logic        legal, den, rdy;
    int          nb, wb;
    cyc++;
    if (!reset_n) begin
      m_valid = 1'b0;
      m_err   = 0;
    end else begin
      rdy = !m_valid || d_ready;
      if (m_valid && d_ready && m_den && m_err < 255) m_err++;
      if (a_valid && rdy) begin
        off   = a_address - BASE;
        nb    = 1 << a_size;
        legal = (a_size <= 4'd2) && ((a_address % nb) == 0);
        lm    = legal ? 4'(((1 << nb) - 1) << (a_address % 4)) : 4'h0;
        den   = !legal || (off >= 4*DEPTH) || (a_opcode inside {3'd2, 3'd3, 3'd6, 3'd7}) ||
                ((a_opcode == 3'd0 || a_opcode == 3'd4) && a_mask != lm) ||
                (a_opcode == 3'd1 && (a_mask & ~lm) != 4'h0);
        wb     = den ? 0 : (int'(off[9:0]) & ~3);
        m_op   = (a_opcode == 3'd5) ? 3'd2 : (a_opcode inside {3'd2, 3'd3, 3'd4}) ? 3'd1 : 3'd0;
        m_size = a_size;
        m_src  = a_source;
        m_den  = den;
        m_cor  = den && (m_op == 3'd1);
        m_data = 32'h0;
        if (a_opcode == 3'd4 && !den)
          m_data = {mbytes[wb+3], mbytes[wb+2], mbytes[wb+1], mbytes[wb]};
        if ((a_opcode == 3'd0 || a_opcode == 3'd1) && !den && !a_corrupt)
          for (int i = 0; i < 4; i++) if (a_mask[i]) mbytes[wb+i] = a_data[8*i +: 8];
        m_valid = 1'b1;
      end else if (m_valid && d_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(posedge clock) begin : compare
    #2;
    if (chk_en) begin
      check("a_ready", {31'b0, a_ready}, {31'b0, reset_n && (!m_valid || d_ready)});
      check("d_valid", {31'b0, d_valid}, {31'b0, m_valid});
      check("err_count", {24'b0, err_count}, {24'b0, 8'(m_err)});
      if (m_valid) begin
        check("d_opcode", {29'b0, d_opcode}, {29'b0, m_op});
        check("d_param", {30'b0, d_param}, 32'h0);
        check("d_size", {28'b0, d_size}, {28'b0, m_size});
        check("d_source", {29'b0, d_source}, {29'b0, m_src});
        check("d_sink", {31'b0, d_sink}, 32'h0);
        check("d_denied", {31'b0, d_denied}, {31'b0, m_den});
        check("d_corrupt", {31'b0, d_corrupt}, {31'b0, m_cor});
        check("d_data", d_data, m_data);
      end
    end
  end

  task automatic set_a(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                       input logic [3:0] msk, input logic [31:0] dat, input logic [SW-1:0] src,
                       input logic cor);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr;
    a_mask = msk; a_data = dat; a_source = src; a_corrupt = cor;
    a_param = 3'($urandom);
  endtask

  // Offer a request at a negedge; return at the negedge after it fires.
  task automatic send(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] addr,
                      input logic [3:0] msk, input logic [31:0] dat, input logic [SW-1:0] src,
                      input logic cor);
    int n;
    n = 0;
    set_a(op, sz, addr, msk, dat, src, cor);
    #1;
    while (!a_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (!a_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: a_ready got 0 expected 1 at t=%0t", $time);
    end
    @(negedge clock);
    a_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int c0;
    logic [2:0] ops [12];
    logic [3:0] sz, msk;
    logic [31:0] addr;
    int r;
    ops = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};

    reset_n = 1'b0; d_ready = 1'b1;
    @(negedge clock);
    chk_en = 1;
    repeat (2) @(negedge clock);
    check("rst_d_valid", {31'b0, d_valid}, 32'h0);
    check("rst_err", {24'b0, err_count}, 32'h0);
    check("rst_d_data", d_data, 32'h0);
    check("rst_a_ready", {31'b0, a_ready}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < DEPTH; i++) send(3'd0, 4'd2, BASE + 4*i, 4'hF, $urandom, SW'(i), 1'b0);

    send(3'd0, 4'd2, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 3'd1, 1'b0);
    check("lit_putfull_op", {29'b0, d_opcode}, 32'd0);
    check("lit_putfull_den", {31'b0, d_denied}, 32'd0);
    send(3'd4, 4'd2, BASE + 32'h10, 4'hF, 32'h0, 3'd2, 1'b0);
    check("lit_get_op", {29'b0, d_opcode}, 32'd1);
    check("lit_get_data", d_data, 32'hDEAD_BEEF);
    send(3'd1, 4'd2, BASE + 32'h10, 4'b0100, 32'h00AB_0000, 3'd3, 1'b0);
    send(3'd4, 4'd2, BASE + 32'h10, 4'hF, 32'h0, 3'd4, 1'b0);
    check("lit_partial_data", d_data, 32'hDEAB_BEEF);
    check("lit_err0", {24'b0, err_count}, 32'd0);
    send(3'd4, 4'd2, BASE + 4*DEPTH, 4'hF, 32'h0, 3'd5, 1'b0);
    check("lit_oor_den", {31'b0, d_denied}, 32'd1);
    check("lit_oor_cor", {31'b0, d_corrupt}, 32'd1);
    check("lit_oor_data", d_data, 32'h0);
    idle(1);
    check("lit_err1", {24'b0, err_count}, 32'd1);

    d_ready = 1'b0;
    send(3'd4, 4'd2, BASE + 32'h10, 4'hF, 32'h0, 3'd6, 1'b0);
    set_a(3'd4, 4'd2, BASE + 32'h14, 4'hF, 32'h0, 3'd5, 1'b0);
    repeat (5) begin
      @(negedge clock);
      check("stall_a_ready", {31'b0, a_ready}, 32'd0);
      check("stall_d_data", d_data, 32'hDEAB_BEEF);
      check("stall_d_source", {29'b0, d_source}, 32'd6);
    end
    d_ready = 1'b1;
    send(3'd4, 4'd2, BASE + 32'h14, 4'hF, 32'h0, 3'd5, 1'b0);
    check("resume_source", {29'b0, d_source}, 32'd5);

    c0 = cyc;
    for (int i = 0; i < DEPTH; i++) send(3'd4, 4'd2, BASE + 4*i, 4'hF, 32'h0, SW'(i), 1'b0);
    check("b2b_cycles", 32'(cyc - c0), 32'd256);
    idle(2);

    for (int it = 0; it < 3000; it++) begin
      d_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) < 7) begin
        sz = ($urandom_range(0, 9) == 0) ? 4'(3 + $urandom_range(0, 12)) : 4'($urandom_range(0, 2));
        r = $urandom_range(0, 9);
        if (r < 8)      addr = BASE + $urandom_range(0, 4*DEPTH - 1);
        else if (r < 9) addr = BASE + 4*DEPTH + $urandom_range(0, 1023);
        else            addr = BASE - $urandom_range(1, 64);
        if (sz <= 4'd2 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
        if (sz <= 4'd2 && $urandom_range(0, 1) == 0)
          msk = 4'(((1 << (1 << sz)) - 1) << (addr % 4));
        else
          msk = 4'($urandom);
        set_a(ops[$urandom_range(0, 11)], sz, addr, msk, $urandom, SW'($urandom),
              ($urandom_range(0, 9) == 0));
      end else begin
        a_valid = 1'b0;
      end
      @(negedge clock);
    end
    a_valid = 1'b0; reset_n = 1'b1; d_ready = 1'b1;
    idle(2);

    d_ready = 1'b0;
    send(3'd4, 4'd2, BASE + 32'h10, 4'hF, 32'h0, 3'd7, 1'b0);
    check("pre_rst_d_valid", {31'b0, d_valid}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_d_valid", {31'b0, d_valid}, 32'd0);
    reset_n = 1'b1; d_ready = 1'b1;
    idle(2);
    check("post_rst_d_valid", {31'b0, d_valid}, 32'd0);

    for (int i = 0; i < 300; i++) send(3'd4, 4'd2, BASE + 4*DEPTH + 4*i, 4'hF, 32'h0, SW'(i), 1'b0);
    idle(2);
    check("err_saturate", {24'b0, err_count}, 32'h0000_00FF);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
